// File: rtl/fa_lut_serial_ctrl.sv
// fa_lut_serial_ctrl: bit-serial adder controller around a lookup-table full adder.
//
// The controller adds two WIDTH-bit operands LSB first, one bit position per clock.
// Each step reads the 8-entry {carry_out, sum} truth table at {a_bit, b_bit, carry}.
// It uses a start/done handshake: start is taken only in IDLE, and done is a one-cycle pulse.
//
// Build option FA_LUT_PROG_EN:
//   Defined:   the table is a register array that resets to the standard full adder.
//              It can be rewritten through cfg_we/cfg_addr/cfg_data, but only while idle.
//   Undefined: the table is constant logic and the cfg_* inputs are ignored.
module fa_lut_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [1:0]       cfg_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Entry i sits at bits [2i+1:2i] as {carry_out, sum}; this is the standard full adder.
  localparam logic [15:0] DEFAULT_TABLE = 16'hE994;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [1:0]       w_table [0:7];
  logic [2:0]       w_addr;
  logic [1:0]       w_entry;
  logic             w_last;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_idx == IW'(WIDTH - 1));
  assign w_addr   = {r_a[r_idx], r_b[r_idx], r_carry};
  assign w_entry  = w_table[w_addr];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_table
`ifdef FA_LUT_PROG_EN
      logic [1:0] r_entry;
      // Table entry: reset to the full adder; rewritten only while idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_entry <= DEFAULT_TABLE[2*gi +: 2];
        end else if ((r_state == S_IDLE) && cfg_we && (cfg_addr == 3'(gi))) begin
          r_entry <= cfg_data;
        end
      end
      assign w_table[gi] = r_entry;
`else
      assign w_table[gi] = DEFAULT_TABLE[2*gi +: 2];
`endif
    end
  endgenerate

`ifndef FA_LUT_PROG_EN
  // The cfg port exists in both builds but has no effect in this one.
  logic w_cfg_unused;
  assign w_cfg_unused = ^{cfg_we, cfg_addr, cfg_data};
`endif

  // Sequencer: capture the operands, step one bit per clock, then hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= w_entry[0];
          r_carry      <= w_entry[1];
          r_idx        <= r_idx + IW'(1);
          if (w_last) begin
            // The final carry is published as cout on the same edge that enters DONE.
            r_cout  <= w_entry[1];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

  // w_accept is kept for readability when debugging start acceptance.
  logic w_accept_unused;
  assign w_accept_unused = w_accept;

endmodule

// File: tb/tb_fa_lut_serial_ctrl.sv
// Testbench for fa_lut_serial_ctrl (WIDTH=8).
// Expected results are computed by a reference bit-serial model that walks the bench's own copy of the truth table.
// Each expected result is pushed onto a queue when start is accepted, and popped when done is seen.
module tb_fa_lut_serial_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [1:0]   cfg_data = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int failures = 0;

  logic [W:0] exp_q [$];
  logic [1:0] tb_tbl [0:7];

  fa_lut_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tbl_default();
    tb_tbl[0] = 2'b00; tb_tbl[1] = 2'b01; tb_tbl[2] = 2'b01; tb_tbl[3] = 2'b10;
    tb_tbl[4] = 2'b01; tb_tbl[5] = 2'b10; tb_tbl[6] = 2'b10; tb_tbl[7] = 2'b11;
  endtask

  function automatic logic [W:0] model_op(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc);
    logic [W-1:0] s;
    logic         c;
    logic [1:0]   e;
    s = '0;
    c = mc;
    for (int i = 0; i < W; i++) begin
      e    = tb_tbl[{ma[i], mb[i], c}];
      s[i] = e[0];
      c    = e[1];
    end
    return {c, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (E0) and queue the expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    a = ia; b = ib; cin = ic; start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back(model_op(ia, ib, ic));
  endtask

  // Count edges after E0 until done is seen (bounded).
  task automatic wait_done(output int lat, output bit seen);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      step();
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, sum, cout} !== '0) begin
      failures++;
      $display("FAIL reset_async: busy=%b done=%b sum=%h cout=%b required all zero", busy, done, sum, cout);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done, sum, cout} !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b sum=%h cout=%b required all zero", busy, done, sum, cout);
    end
    $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
  endtask

  task automatic test_basic();
    logic [W-1:0] va [3] = '{8'hA5, 8'hFF, 8'h00};
    logic [W-1:0] vb [3] = '{8'h3C, 8'h01, 8'h00};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    bit seen;
    logic [W:0] e;
    for (int t = 0; t < 3; t++) begin
      issue(va[t], vb[t], vc[t]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_busy[%0d]: busy=%b required 1", t, busy);
      end
      wait_done(lat, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || lat != W) begin
        failures++;
        $display("FAIL basic_latency[%0d]: seen=%b latency=%0d required %0d", t, seen, lat, W);
      end
      checks++;
      if ({cout, sum} !== e) begin
        failures++;
        $display("FAIL basic_result[%0d]: cout=%b sum=%h required cout=%b sum=%h", t, cout, sum, e[W], e[W-1:0]);
      end
      $display("basic: a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", va[t], vb[t], vc[t], sum, cout, lat);
      step();
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    int lat = 0;
    logic [W:0] e;
    logic [W:0] got = '0;
    issue(8'h5A, 8'h6B, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      if (n >= 1 && n <= 4) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      step();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin lat = n; got = {cout, sum}; end
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (ndone != 1 || lat != W) begin
      failures++;
      $display("FAIL ignore_start_done: dones=%0d latency=%0d required 1 and %0d", ndone, lat, W);
    end
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL ignore_start_result: got=%h required %h", got, e);
    end
    $display("start_ignored: dones=%0d sum=%h cout=%b", ndone, got[W-1:0], got[W]);
  endtask

  task automatic test_back_to_back();
    int dt [$];
    logic [W:0] e;
    a = 8'h0F; b = 8'hF0; cin = 1'b1; start = 1'b1;
    step();
    exp_q.push_back(model_op(8'h0F, 8'hF0, 1'b1));
    a = 8'h33; b = 8'h44; cin = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (n == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle_gap: busy=%b required 0", busy);
        end
      end
      if (n == 10) begin
        start = 1'b0;
        exp_q.push_back(model_op(8'h33, 8'h44, 1'b0));
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_second_accept: busy=%b required 1", busy);
        end
      end
      if (done === 1'b1) begin
        dt.push_back(n);
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
          failures++;
          $display("FAIL b2b_result@%0d: got=%h required %h", n, {cout, sum}, e);
        end
        $display("back_to_back: done at edge %0d sum=%h cout=%b", n, sum, cout);
      end
    end
    start = 1'b0;
    checks++;
    if (dt.size() != 2 || dt[0] != W || dt[1] != 2*W + 2) begin
      failures++;
      $display("FAIL b2b_timing: dones=%0d first=%0d second=%0d required %0d and %0d",
               dt.size(), (dt.size() > 0) ? dt[0] : -1, (dt.size() > 1) ? dt[1] : -1, W, 2*W+2);
    end
  endtask

  task automatic test_cfg_write();
    int addrs [4] = '{3, 5, 6, 7};
    logic [2:0] ad;
    int lat;
    bit seen;
    logic [W:0] e;
    for (int k = 0; k < 4; k++) begin
      ad = 3'(addrs[k]);
      cfg_we = 1'b1; cfg_addr = ad; cfg_data = {1'b0, tb_tbl[ad][0]};
`ifdef FA_LUT_PROG_EN
      tb_tbl[ad] = {1'b0, tb_tbl[ad][0]};
`endif
      step();
    end
    cfg_we = 1'b0;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(lat, seen);
    e = exp_q.pop_front();
    checks++;
`ifdef FA_LUT_PROG_EN
    if (!seen || {cout, sum} !== e || e !== 9'h0FE) begin
`else
    if (!seen || {cout, sum} !== e || e !== 9'h100) begin
`endif
      failures++;
      $display("FAIL cfg_write_result: seen=%b got=%h required %h", seen, {cout, sum}, e);
    end
    $display("cfg_write: FF+01 -> sum=%h cout=%b", sum, cout);
    step();
  endtask

  task automatic test_cfg_busy();
    int lat;
    bit seen;
    logic [W:0] e;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tbl_default();
    step();
    issue(8'h12, 8'h34, 1'b0);
    step(); step();
    cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 2'b00;
    step();
    cfg_we = 1'b0;
    wait_done(lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {cout, sum} !== e) begin
      failures++;
      $display("FAIL cfg_busy_op: seen=%b got=%h required %h", seen, {cout, sum}, e);
    end
    step();
    issue(8'hFF, 8'hFF, 1'b0);
    wait_done(lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {cout, sum} !== 9'h1FE || e !== 9'h1FE) begin
      failures++;
      $display("FAIL cfg_busy_dropped: seen=%b got=%h required 1fe", seen, {cout, sum});
    end
    $display("cfg_busy: FF+FF -> sum=%h cout=%b", sum, cout);
    step();
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int lat;
    bit seen;
    logic [W:0] e;
    issue(8'hC3, 8'h3C, 1'b1);
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({busy, done, sum, cout} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b required all zero", busy, done, sum, cout);
    end
    step();
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: dones=%0d required 0", ndone);
    end
    issue(8'h10, 8'h20, 1'b0);
    wait_done(lat, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || {cout, sum} !== e || e !== 9'h030) begin
      failures++;
      $display("FAIL reset_mid_after: seen=%b got=%h required 030", seen, {cout, sum});
    end
    $display("reset_mid: 10+20 -> sum=%h cout=%b", sum, cout);
    step();
  endtask

  initial begin
    tbl_default();
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_cfg_write();
    test_cfg_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
